if_stage: RTL

- Instruction-fetch front end of the openmips core.
- Generates the PC and drives the instruction ROM request (rom_ce / rom_addr); the ROM is combinational and returns rom_data in the same cycle.
- Registers the fetched word and its PC into the IF/ID pipeline latch for the decode stage.
- Handles pipeline stall, branch redirect and exception flush.

---
 rtl/if_stage_pkg.sv | 27 ++
 rtl/if_pc_gen.sv | 61 ++++++
 rtl/if_stage.sv | 102 ++++++++++
 3 files changed

// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_stage_pkg;

    localparam int InstAddrBusW = 32;
    localparam int InstBusW     = 32;

    localparam logic [InstAddrBusW-1:0] ZeroWord = 32'h0000_0000;
    localparam logic [InstBusW-1:0]     NopInst  = 32'h0000_0000;

    localparam logic RstEnable   = 1'b0;
    localparam logic ChipEnable  = 1'b1;
    localparam logic ChipDisable = 1'b0;

    // Source selected for the next PC value.
    typedef enum logic [1:0] {
        PC_HOLD   = 2'd0,
        PC_SEQ    = 2'd1,
        PC_BRANCH = 2'd2,
        PC_FLUSH  = 2'd3
    } pc_sel_e;

    // Instruction addresses are always word aligned.
    function automatic logic [InstAddrBusW-1:0] word_align(input logic [InstAddrBusW-1:0] a);
        return {a[InstAddrBusW-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_pc_gen.sv
// PC register, ROM chip-enable and next-PC selection.
// Redirect priority: flush, stall, branch, sequential.
module if_pc_gen
    import if_stage_pkg::*;
#(
    parameter logic [InstAddrBusW-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    stall_i,
    input  logic                    branch_flag_i,
    input  logic [InstAddrBusW-1:0] branch_target_i,
    input  logic                    flush_i,
    input  logic [InstAddrBusW-1:0] new_pc_i,
    output logic                    rom_ce_o,
    output logic [InstAddrBusW-1:0] pc_o,
    output logic                    branch_taken_o
);

    logic                    rom_ce_q;
    logic [InstAddrBusW-1:0] pc_q, pc_d;
    pc_sel_e                 pc_sel;

    // Next-PC source selection; nothing advances until the ROM is enabled.
    always_comb begin
        pc_sel = PC_HOLD;
        if (rom_ce_q == ChipEnable) begin
            if (flush_i)            pc_sel = PC_FLUSH;
            else if (stall_i)       pc_sel = PC_HOLD;
            else if (branch_flag_i) pc_sel = PC_BRANCH;
            else                    pc_sel = PC_SEQ;
        end
    end

    // Next-PC mux; sequential increment wraps modulo 2^32.
    always_comb begin
        pc_d = pc_q;
        unique case (pc_sel)
            PC_FLUSH:  pc_d = word_align(new_pc_i);
            PC_BRANCH: pc_d = word_align(branch_target_i);
            PC_SEQ:    pc_d = pc_q + 32'd4;
            default:   pc_d = pc_q;
        endcase
    end

    // PC and chip-enable registers; enable rises on the first edge after reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (rst_ni == RstEnable) begin
            rom_ce_q <= ChipDisable;
            pc_q     <= RESET_PC;
        end else begin
            rom_ce_q <= ChipEnable;
            pc_q     <= pc_d;
        end
    end

    assign rom_ce_o       = rom_ce_q;
    assign pc_o           = pc_q;
    assign branch_taken_o = (pc_sel == PC_BRANCH);

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch front end: PC generation plus the IF/ID pipeline latch.
// Optional macro IF_DELAY_SLOT_EN: when defined, the sequential instruction
// fetched alongside an accepted branch enters ID (MIPS delay slot); when
// undefined it is replaced by a bubble.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [InstAddrBusW-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [InstBusW-1:0]     NOP_INST = NopInst
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    stall_if_i,
    input  logic                    stall_id_i,
    input  logic                    branch_flag_i,
    input  logic [InstAddrBusW-1:0] branch_target_i,
    input  logic                    flush_i,
    input  logic [InstAddrBusW-1:0] new_pc_i,
    output logic                    rom_ce_o,
    output logic [InstAddrBusW-1:0] rom_addr_o,
    input  logic [InstBusW-1:0]     rom_data_i,
    output logic [InstAddrBusW-1:0] id_pc_o,
    output logic [InstBusW-1:0]     id_inst_o,
    output logic                    id_valid_o
);

    logic                    stall_pc;
    logic                    rom_ce;
    logic [InstAddrBusW-1:0] pc;
    logic                    branch_taken;

    logic [InstAddrBusW-1:0] id_pc_q, id_pc_d;
    logic [InstBusW-1:0]     id_inst_q, id_inst_d;
    logic                    id_valid_q, id_valid_d;

    // A stalled ID with a running IF is illegal; treat it as an IF stall.
    assign stall_pc = stall_if_i | stall_id_i;

    if_pc_gen #(
        .RESET_PC (RESET_PC)
    ) u_pc_gen (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .stall_i         (stall_pc),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .flush_i         (flush_i),
        .new_pc_i        (new_pc_i),
        .rom_ce_o        (rom_ce),
        .pc_o            (pc),
        .branch_taken_o  (branch_taken)
    );

    // IF/ID latch next state: flush, hold on ID stall, bubble on IF stall, else load.
    always_comb begin
        id_pc_d    = id_pc_q;
        id_inst_d  = id_inst_q;
        id_valid_d = id_valid_q;
        if (flush_i || (stall_pc && !stall_id_i)) begin
            id_pc_d    = ZeroWord;
            id_inst_d  = NOP_INST;
            id_valid_d = 1'b0;
        end else if (!stall_id_i) begin
            id_pc_d    = pc;
            id_inst_d  = rom_data_i;
            id_valid_d = rom_ce;
`ifndef IF_DELAY_SLOT_EN
            if (branch_taken) begin
                id_pc_d    = ZeroWord;
                id_inst_d  = NOP_INST;
                id_valid_d = 1'b0;
            end
`endif
        end
    end

    // IF/ID pipeline register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (rst_ni == RstEnable) begin
            id_pc_q    <= ZeroWord;
            id_inst_q  <= NOP_INST;
            id_valid_q <= 1'b0;
        end else begin
            id_pc_q    <= id_pc_d;
            id_inst_q  <= id_inst_d;
            id_valid_q <= id_valid_d;
        end
    end

    assign rom_ce_o   = rom_ce;
    assign rom_addr_o = pc;
    assign id_pc_o    = id_pc_q;
    assign id_inst_o  = id_inst_q;
    assign id_valid_o = id_valid_q;

`ifndef SYNTHESIS
    // ID may only stall together with IF.
    a_stall_order: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                    !(stall_id_i && !stall_if_i));
`endif

endmodule
